// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module : lcd_pkg
// Brief  : Shared definitions for the LCD/HDMI pixel path: feeder state
//          encoding, pixel counter width and default display geometry.
// Rev    : 1.0  initial release
// ============================================================================
package lcd_pkg;

  // Feeder state encoding
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FLUSH = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = IDLE,
    S_FLUSH = FLUSH,
    S_RUN   = RUN,
    S_DONE  = DONE
  } state_t;

  // Wide enough for 1920*1080 = 2,073,600 pixels per frame
  localparam int PIX_CNT_W = 22;

  // Default geometry, shared with the timing generator
  localparam int DEF_H_DISP = 1920;
  localparam int DEF_V_DISP = 1080;

endpackage
`default_nettype wire

// File: rtl/pix_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module : pix_sync_fifo
// Brief  : Single-clock FIFO with registered read data (block-RAM style),
//          synchronous pointer clear and a registered occupancy count.
// Rev    : 1.0  initial release
// ============================================================================
module pix_sync_fifo #(
  parameter int DATA_W  = 16,
  parameter int FIFO_AW = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [FIFO_AW:0]  level
);

  localparam int DEPTH = 2 ** FIFO_AW;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic [FIFO_AW:0]  wr_ptr_q;
  logic [FIFO_AW:0]  rd_ptr_q;
  logic [FIFO_AW:0]  level_q;
  logic [FIFO_AW:0]  level_d;
  logic              w_wr;
  logic              w_rd;

  // Extra pointer MSB distinguishes full from empty when the low bits match
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                 (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);

  // Accesses that would corrupt the pointers are dropped here as a backstop
  assign w_wr = wr_en && !full;
  assign w_rd = rd_en && !empty;

  assign rd_data = rd_data_q;
  assign level   = level_q;

  // Storage array and read register, no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (w_wr) begin
      mem_q[wr_ptr_q[FIFO_AW-1:0]] <= wr_data;
    end
    if (w_rd) begin
      rd_data_q <= mem_q[rd_ptr_q[FIFO_AW-1:0]];
    end
  end

  // Next occupancy follows the accesses actually performed this cycle
  always_comb begin
    level_d = level_q;
    case ({w_wr, w_rd})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Pointers and occupancy; clr empties the FIFO in one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (w_wr) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (w_rd) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      level_q <= level_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/lcd_pixel_feeder.sv
`default_nettype none
// ============================================================================
// Module : lcd_pixel_feeder
// Brief  : Buffers frame-buffer pixels and hands one to the timing generator
//          per data_req with one cycle of latency; re-aligns on every frame
//          start and flags underflow and short frames.
// Rev    : 1.0  initial release
// ============================================================================
module lcd_pixel_feeder
  import lcd_pkg::*;
#(
  parameter int                DATA_W      = 16,
  parameter int                FIFO_AW     = 11,
  parameter int                H_DISP      = DEF_H_DISP,
  parameter int                V_DISP      = DEF_V_DISP,
  parameter logic [DATA_W-1:0] UFLOW_COLOR = DATA_W'(16'hF800)
) (
  input  logic              pixel_clk,
  input  logic              sys_rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              frame_start_req,
  input  logic              frst_pos,
  input  logic              data_req,
  output logic [DATA_W-1:0] pixel_data,
  output logic [FIFO_AW:0]  fifo_level,
  output logic [15:0]       uflow_cnt,
  output logic              err_uflow,
  output logic              err_short,
  input  logic              err_clr
);

  localparam logic [PIX_CNT_W-1:0] c_PIX_LAST = PIX_CNT_W'(H_DISP * V_DISP - 1);

  state_t                state_q;
  logic [PIX_CNT_W-1:0]  pix_cnt_q;
  logic                  fifo_sel_q;
  logic                  uflow_sel_q;
  logic [15:0]           uflow_cnt_q;
  logic [15:0]           uflow_cnt_d;
  logic                  err_uflow_q;
  logic                  err_uflow_d;
  logic                  err_short_q;
  logic                  err_short_d;

  logic                  w_run;
  logic                  w_slot;
  logic                  w_rd_en;
  logic                  w_uflow;
  logic                  w_push;
  logic                  w_full;
  logic                  w_empty;
  logic [DATA_W-1:0]     w_rd_data;

  // A frame start overrides any pixel request in the same cycle
  assign w_run   = (state_q == S_RUN);
  assign w_slot  = w_run && data_req && !frst_pos;
  assign w_rd_en = w_slot && !w_empty;
  assign w_uflow = w_slot && w_empty;
  assign w_push  = s_valid && s_ready;

  assign s_ready         = w_run && !w_full;
  assign frame_start_req = (state_q == S_FLUSH);

  pix_sync_fifo #(
    .DATA_W  (DATA_W),
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk     (pixel_clk),
    .rst     (sys_rst),
    .clr     (frame_start_req),
    .wr_en   (w_push),
    .wr_data (s_data),
    .rd_en   (w_rd_en),
    .rd_data (w_rd_data),
    .full    (w_full),
    .empty   (w_empty),
    .level   (fifo_level)
  );

  // Frame sequencing and pixel counter; underflow slots still count
  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= S_IDLE;
      pix_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (frst_pos) state_q <= S_FLUSH;
        end
        S_FLUSH: begin
          pix_cnt_q <= '0;
          state_q   <= S_RUN;
        end
        S_RUN: begin
          if (frst_pos) begin
            state_q <= S_FLUSH;
          end else if (data_req) begin
            pix_cnt_q <= pix_cnt_q + 1'b1;
            if (pix_cnt_q == c_PIX_LAST) state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (frst_pos) state_q <= S_FLUSH;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Output source select, aligned with the FIFO's registered read data
  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      fifo_sel_q  <= 1'b0;
      uflow_sel_q <= 1'b0;
    end else begin
      fifo_sel_q  <= w_rd_en;
      uflow_sel_q <= w_uflow;
    end
  end

  assign pixel_data = fifo_sel_q  ? w_rd_data   :
                      uflow_sel_q ? UFLOW_COLOR : '0;

  // Error next-state: a clear beats any coincident new error
  always_comb begin
    uflow_cnt_d = uflow_cnt_q;
    err_uflow_d = err_uflow_q;
    err_short_d = err_short_q;
    if (err_clr) begin
      uflow_cnt_d = '0;
      err_uflow_d = 1'b0;
      err_short_d = 1'b0;
    end else begin
      if (w_uflow) begin
        err_uflow_d = 1'b1;
        if (uflow_cnt_q != 16'hFFFF) uflow_cnt_d = uflow_cnt_q + 1'b1;
      end
      if (w_run && frst_pos) err_short_d = 1'b1;
    end
  end

  // Error and statistics registers
  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      uflow_cnt_q <= '0;
      err_uflow_q <= 1'b0;
      err_short_q <= 1'b0;
    end else begin
      uflow_cnt_q <= uflow_cnt_d;
      err_uflow_q <= err_uflow_d;
      err_short_q <= err_short_d;
    end
  end

  assign uflow_cnt = uflow_cnt_q;
  assign err_uflow = err_uflow_q;
  assign err_short = err_short_q;

endmodule
`default_nettype wire
